// File: rtl/delay_ring_buffer.sv
// Sample-counted programmable delay line over a circular RAM with a wrapping write pointer.
// Optional build macro DELAY_RING_ZERO_FILL_EN: every accept is valid, warm-up samples read as zero.
module delay_ring_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DELAY  = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            Data_In,
  input  logic                             In_Valid,
  input  logic [$clog2(MAX_DELAY):0]       Delay_Len,
  input  logic                             Flush,
  output logic [DATA_WIDTH-1:0]            Data_Out,
  output logic                             Out_Valid,
  output logic [$clog2(MAX_DELAY):0]       Fill_Count
);

  localparam int ADDR_WIDTH = $clog2(MAX_DELAY);
  localparam int CNT_W      = ADDR_WIDTH + 1;

  typedef logic [CNT_W-1:0]      cnt_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam cnt_t  MAX_CNT  = cnt_t'(MAX_DELAY);
  localparam addr_t LAST_PTR = addr_t'(MAX_DELAY - 1);

  // Zero is treated as one and anything past the storage depth as the full depth.
  function automatic cnt_t clamp_delay(input cnt_t len);
    if (len == '0)     return cnt_t'(1);
    if (len > MAX_CNT) return MAX_CNT;
    return len;
  endfunction

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c >= MAX_CNT) ? MAX_CNT : c + cnt_t'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
  addr_t                 wr_ptr;
  cnt_t                  d_eff;
  cnt_t                  wr_ext;
  cnt_t                  rd_ext;
  addr_t                 rd_addr;
  logic                  accept;

  assign accept = In_Valid & ~Flush;
  assign d_eff  = clamp_delay(Delay_Len);
  assign wr_ext = {1'b0, wr_ptr};

  // Modular subtraction that also holds for depths that are not a power of two.
  always_comb begin
    rd_ext = '0;
    if (wr_ext >= d_eff) rd_ext = wr_ext - d_eff;
    else                 rd_ext = wr_ext + MAX_CNT - d_eff;
    rd_addr = rd_ext[ADDR_WIDTH-1:0];
  end

  // Storage write; the registered read below sees the pre-write word when addresses coincide.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= Data_In;
  end

  // Output stage: one register after the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      Fill_Count <= '0;
      Data_Out   <= '0;
      Out_Valid  <= 1'b0;
    end else if (Flush) begin
      wr_ptr     <= '0;
      Fill_Count <= '0;
      Out_Valid  <= 1'b0;
    end else if (In_Valid) begin
`ifdef DELAY_RING_ZERO_FILL_EN
      Data_Out   <= (Fill_Count < d_eff) ? '0 : mem[rd_addr];
      Out_Valid  <= 1'b1;
`else
      Data_Out   <= mem[rd_addr];
      Out_Valid  <= (Fill_Count >= d_eff);
`endif
      wr_ptr     <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + addr_t'(1);
      Fill_Count <= sat_inc(Fill_Count);
    end else begin
      Out_Valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_delay_ring_buffer.sv
// Directed bench for delay_ring_buffer; expectations follow the build macro DELAY_RING_ZERO_FILL_EN.
module tb_delay_ring_buffer;

  localparam int DW = 16;
  localparam int MD = 32;
  localparam int LW = $clog2(MD) + 1;
`ifdef DELAY_RING_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          in_valid = 1'b0;
  logic [LW-1:0] delay_len = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic [LW-1:0] fill_count;

  int vectors = 0;
  int miscompares = 0;

  delay_ring_buffer #(.DATA_WIDTH(DW), .MAX_DELAY(MD)) dut (
    .clk        (clk),
    .reset      (reset),
    .Data_In    (data_in),
    .In_Valid   (in_valid),
    .Delay_Len  (delay_len),
    .Flush      (flush),
    .Data_Out   (data_out),
    .Out_Valid  (out_valid),
    .Fill_Count (fill_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic vld, input logic [DW-1:0] d, input logic [LW-1:0] len,
                       input logic fl);
    in_valid  = vld;
    data_in   = d;
    delay_len = len;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Accept one sample; base_vld/base_dat are the valid-gated expectations, the zero-fill
  // build turns every non-valid accept into a valid zero.
  task automatic acc(input string tag, input logic [DW-1:0] d, input logic [LW-1:0] len,
                     input logic base_vld, input logic [DW-1:0] base_dat);
    logic          ev;
    logic [DW-1:0] ed;
    ev = ZF ? 1'b1 : base_vld;
    ed = (ZF && !base_vld) ? '0 : base_dat;
    cycle(1'b1, d, len, 1'b0);
    chk({tag, ".vld"}, out_valid, ev);
    if (ev) chk({tag, ".dat"}, data_out, ed);
  endtask

  task automatic idle(input string tag, input logic [DW-1:0] hold);
    cycle(1'b0, '0, delay_len, 1'b0);
    chk({tag, ".idle_vld"}, out_valid, 0);
    chk({tag, ".idle_hold"}, data_out, hold);
  endtask

  task automatic do_flush(input string tag, input logic [DW-1:0] hold);
    cycle(1'b1, 16'd99, delay_len, 1'b1);
    chk({tag, ".fl_fill"}, fill_count, 0);
    chk({tag, ".fl_vld"}, out_valid, 0);
    chk({tag, ".fl_hold"}, data_out, hold);
  endtask

  initial begin
    #12;
    chk("rst.dat", data_out, 0);
    chk("rst.vld", out_valid, 0);
    chk("rst.fill", fill_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Delay 3, samples 1..6 back to back.
    for (int k = 1; k <= 6; k++)
      acc($sformatf("d3.s%0d", k), DW'(k), LW'(3), k >= 4, (k >= 4) ? DW'(k - 3) : '0);
    chk("d3.fill", fill_count, 6);
    idle("d3", 16'd3);

    // Flush drops a concurrent sample, then delay 1 gives a single output 7.
    do_flush("f1", 16'd3);
    acc("f1.s7", 16'd7, LW'(1), 1'b0, '0);
    acc("f1.s8", 16'd8, LW'(1), 1'b1, 16'd7);
    chk("f1.fill", fill_count, 2);

    // Delay 2 on a gapped stream; output holds across idle cycles.
    do_flush("g2", 16'd7);
    acc("g2.s10", 16'd10, LW'(2), 1'b0, '0);
    idle("g2a", data_out);
    idle("g2b", data_out);
    acc("g2.s20", 16'd20, LW'(2), 1'b0, '0);
    idle("g2c", data_out);
    idle("g2d", data_out);
    acc("g2.s30", 16'd30, LW'(2), 1'b1, 16'd10);
    idle("g2e", 16'd10);
    idle("g2f", 16'd10);
    acc("g2.s40", 16'd40, LW'(2), 1'b1, 16'd20);

    // Full-depth delay (and an over-range request clamped to it) with pointer wrap.
    for (int r = 0; r < 2; r++) begin
      do_flush($sformatf("m%0d", r), data_out);
      for (int k = 0; k <= 40; k++)
        acc($sformatf("m%0d.s%0d", r, k), DW'(k + 100 * r), (r == 0) ? LW'(32) : LW'(40),
            k >= 32, (k >= 32) ? DW'(k - 32 + 100 * r) : '0);
      chk($sformatf("m%0d.fill", r), fill_count, 32);
    end

    // Delay 0 behaves as delay 1.
    do_flush("z0", data_out);
    acc("z0.s5", 16'd5, LW'(0), 1'b0, '0);
    acc("z0.s6", 16'd6, LW'(0), 1'b1, 16'd5);
    acc("z0.s7", 16'd7, LW'(0), 1'b1, 16'd6);

    // Asynchronous reset mid-stream, then refill from scratch.
    do_flush("r", data_out);
    acc("r.s1", 16'd1, LW'(2), 1'b0, '0);
    acc("r.s2", 16'd2, LW'(2), 1'b0, '0);
    acc("r.s3", 16'd3, LW'(2), 1'b1, 16'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("r.async_dat", data_out, 0);
    chk("r.async_vld", out_valid, 0);
    chk("r.async_fill", fill_count, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    acc("r.s4", 16'd4, LW'(2), 1'b0, '0);
    acc("r.s5", 16'd5, LW'(2), 1'b0, '0);
    acc("r.s6", 16'd6, LW'(2), 1'b1, 16'd4);
    chk("r.fill", fill_count, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
